bram_stream_reader: RTL and testbench

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

---
 rtl/bram_stream_reader.sv | 110 +++++++++++
 tb/tb_bram_stream_reader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// Burst reader from a synchronous-read RAM into a valid/ready stream; 3 cycles from start to first beat.
// Reads are throttled so in-flight reads plus buffered words never exceed the 2-entry FIFO under backpressure.
module bram_stream_reader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [$clog2(DEPTH)-1:0] base_addr,
    input  logic [$clog2(DEPTH):0]   length,
    output logic                    enb,
    output logic [$clog2(DEPTH)-1:0] addrb,
    input  logic [WIDTH-1:0]        dob,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [WIDTH-1:0]        m_data,
    output logic                    m_last,
    output logic                    busy,
    output logic                    done
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   ONE       = (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   rd_left;
    logic [ADDR_WIDTH:0]   beat_left;
    logic                  rd_pend;
    logic [WIDTH-1:0]      fifo_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_count;
    logic                  push;
    logic                  pop;
    logic [2:0]            occ;

    assign push    = rd_pend;
    assign m_valid = (fifo_count != 2'd0);
    assign pop     = m_valid && m_ready;
    // Words that will still hold a FIFO slot after this cycle's pop.
    assign occ     = {2'b00, rd_pend} + {1'b0, fifo_count} - {2'b00, pop};
    assign enb     = (state == RUN) && (rd_left != '0) && (occ < 3'd2);
    assign addrb   = addr;
    assign m_data  = fifo_mem[rd_ptr];
    assign m_last  = m_valid && (beat_left == ONE);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            rd_left    <= '0;
            beat_left  <= '0;
            rd_pend    <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            done       <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            done       <= 1'b0;
            rd_pend    <= enb;
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
            if (push) begin
                fifo_mem[wr_ptr] <= dob;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr    <= ~rd_ptr;
                beat_left <= beat_left - ONE;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            addr      <= base_addr;
                            rd_left   <= length;
                            beat_left <= length;
                            state     <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (enb) begin
                        addr    <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
                        rd_left <= rd_left - ONE;
                        if (rd_left == ONE) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && (beat_left == ONE)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural RAM (RAM[i] = i + 0x100) and a stream monitor.
module tb_bram_stream_reader;
    localparam int WIDTH = 32;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [AW:0]      length;
    logic             enb;
    logic [AW-1:0]    addrb;
    logic [WIDTH-1:0] dob;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] ram [DEPTH];
    int addr_q[$];
    int beat_q[$];
    int last_q[$];
    int done_cnt  = 0;
    int viol      = 0;
    int stab_viol = 0;
    int inflight  = 0;
    logic             prev_hold = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    logic             prev_last = 1'b0;

    bram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .length(length), .enb(enb), .addrb(addrb), .dob(dob),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (enb) dob <= ram[addrb];
    end

    // Stream monitor: logs reads/beats and checks FIFO occupancy bound and beat stability.
    always @(negedge clk) begin
        logic p;
        #2;
        p = m_valid && m_ready;
        if (rst_n) begin
            if (prev_hold && (!m_valid || m_data !== prev_data || m_last !== prev_last))
                stab_viol++;
            if (enb) begin
                addr_q.push_back(int'(addrb));
                if (inflight - int'(p) >= 2) viol++;
            end
            if (p) begin
                beat_q.push_back(int'(m_data));
                last_q.push_back(int'(m_last));
            end
            if (done) done_cnt++;
            inflight  = inflight + int'(enb) - int'(p);
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
        end else begin
            inflight  = 0;
            prev_hold = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        addr_q.delete();
        beat_q.delete();
        last_q.delete();
        done_cnt  = 0;
        viol      = 0;
        stab_viol = 0;
    endtask

    // Pulses start for one cycle; returns at the negedge of cycle 1.
    task automatic go(input int b, input int l);
        start     = 1'b1;
        base_addr = AW'(b);
        length    = (AW+1)'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns #1 after the negedge of the cycle where done is high.
    task automatic wait_done(input int budget, input bit rnd);
        int n = 0;
        #1;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            #1;
            n++;
        end
        chk("done_within_budget", {63'd0, done}, 64'd1);
    endtask

    task automatic chk_beats(input string tag, input int b, input int l);
        chk({tag, "_beat_count"}, 64'(beat_q.size()), 64'(l));
        for (int i = 0; i < l; i++) begin
            chk($sformatf("%s_beat%0d", tag, i), 64'(beat_q[i]), 64'(((b + i) % DEPTH) + 256));
            chk($sformatf("%s_last%0d", tag, i), 64'(last_q[i]), 64'(i == l - 1));
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = WIDTH'(i + 256);
        rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
        #1;
        chk("rst_enb", {63'd0, enb}, 64'd0);
        chk("rst_addrb", 64'(addrb), 64'd0);
        chk("rst_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_data", 64'(m_data), 64'd0);
        chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic burst base=4 length=3, sink always ready.
        clear_logs();
        go(4, 3);
        #1; chk("b1_c1", {enb, busy, m_valid, 8'(addrb)}, {3'b110, 8'd4});
        @(negedge clk); #1; chk("b1_c2", {enb, m_valid, 8'(addrb)}, {2'b10, 8'd5});
        @(negedge clk); #1; chk("b1_c3", {enb, m_valid, m_last, 8'(addrb), m_data}, {3'b110, 8'd6, 32'h104});
        @(negedge clk); #1; chk("b1_c4", {enb, m_valid, m_last, m_data}, {3'b010, 32'h105});
        @(negedge clk); #1; chk("b1_c5", {enb, m_valid, m_last, busy, m_data}, {4'b0111, 32'h106});
        @(negedge clk); #1; chk("b1_c6", {done, busy, m_valid}, 3'b100);
        @(negedge clk); #1; chk("b1_c7_done_drop", {63'd0, done}, 64'd0);
        chk_beats("b1", 4, 3);

        // Address wrap from 254.
        @(negedge clk);
        clear_logs();
        go(254, 4);
        wait_done(40, 1'b0);
        chk("wrap_reads", 64'(addr_q.size()), 64'd4);
        chk("wrap_a0", 64'(addr_q[0]), 64'd254);
        chk("wrap_a1", 64'(addr_q[1]), 64'd255);
        chk("wrap_a2", 64'(addr_q[2]), 64'd0);
        chk("wrap_a3", 64'(addr_q[3]), 64'd1);
        chk_beats("wrap", 254, 4);

        // Random backpressure.
        @(negedge clk);
        clear_logs();
        go(40, 8);
        wait_done(300, 1'b1);
        m_ready = 1'b1;
        chk_beats("rnd", 40, 8);
        chk("rnd_occupancy_viol", 64'(viol), 64'd0);
        chk("rnd_hold_viol", 64'(stab_viol), 64'd0);

        // Zero-length command.
        @(negedge clk);
        clear_logs();
        go(9, 0);
        #1; chk("len0_c1", {done, enb, m_valid, busy}, 4'b1000);
        @(negedge clk); #1; chk("len0_c2", {done, busy}, 2'b00);
        chk("len0_no_reads", 64'(addr_q.size() + beat_q.size()), 64'd0);

        // Reset during beat 2 of a 6-word burst.
        @(negedge clk);
        go(10, 6);
        @(negedge clk); @(negedge clk); #1;
        chk("rst_mid_beat1", {m_valid, m_data}, {1'b1, 32'h10a});
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_zero", {enb, m_valid, m_last, busy, done, 8'(addrb), m_data}, 45'd0);
        @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) @(negedge clk);
        #1;
        chk("rst_mid_idle", {m_valid, busy}, 2'b00);
        chk("rst_mid_no_activity", 64'(addr_q.size() + beat_q.size()), 64'd0);
        chk("rst_mid_no_done", 64'(done_cnt), 64'd0);

        // Start while busy is ignored; start in done cycle is accepted.
        @(negedge clk);
        clear_logs();
        go(20, 3);
        start = 1'b1; base_addr = 8'd100; length = 9'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(40, 1'b0);
        chk_beats("ign", 20, 3);
        clear_logs();
        start = 1'b1; base_addr = 8'd30; length = 9'd2;
        @(negedge clk);
        start = 1'b0;
        #1; chk("back2back_c1", {enb, busy, 8'(addrb)}, {2'b11, 8'd30});
        wait_done(40, 1'b0);
        chk_beats("b2b", 30, 2);

        // Full-depth burst from base 7.
        @(negedge clk);
        clear_logs();
        go(7, 256);
        wait_done(400, 1'b0);
        begin
            int errs = 0;
            bit seen [DEPTH];
            for (int i = 0; i < DEPTH; i++) seen[i] = 1'b0;
            foreach (addr_q[i]) seen[addr_q[i] % DEPTH] = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (!seen[i]) errs++;
                if (i < beat_q.size() && beat_q[i] != ((7 + i) % DEPTH) + 256) errs++;
                if (i < last_q.size() && last_q[i] != int'(i == DEPTH - 1)) errs++;
            end
            chk("full_reads", 64'(addr_q.size()), 64'd256);
            chk("full_beats", 64'(beat_q.size()), 64'd256);
            chk("full_errs", 64'(errs), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
